// File: rtl/mhsa_mem_pkg.sv
// Shared constants and state encoding for the key-weight memory fetch path.
package mhsa_mem_pkg;

  localparam int WIDTH       = 64;
  localparam int LENGTH      = 4096;
  localparam int WEIGHT_SIZE = 2048;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/wk_skid_fifo.sv
// Two-entry FIFO that absorbs the one-cycle memory read latency.
// The controller never pushes into a full FIFO; a pop on an empty FIFO is ignored.
module wk_skid_fifo #(
  parameter int DW = 65
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [1:0]    count
);

  logic [DW-1:0] r_slot0;
  logic [DW-1:0] r_slot1;
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_count;
  logic          w_pop;

  assign w_pop     = pop & (r_count != 2'd0);
  assign head_data = r_rd_ptr ? r_slot1 : r_slot0;
  assign count     = r_count;

  // Storage, pointers and occupancy; clear empties the FIFO and zeroes the slots.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_slot0  <= '0;
      r_slot1  <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        if (r_wr_ptr) r_slot1 <= push_data;
        else          r_slot0 <= push_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wk_fetch_ctrl.sv
// Key-weight memory sequencer: arbitrates the single memory port between the
// weight loader (writes, only while idle) and a burst reader that streams a
// contiguous word range to the K-projection datapath.
//
// Handshakes: a word moves on a stream when valid & ready are both high at a
// rising clock edge. valid never depends on ready; once raised, valid and its
// payload hold until the transfer happens. ld_ready is combinational (high in
// IDLE) so a loader write lands in the same cycle it is offered.
module wk_fetch_ctrl #(
  parameter int WIDTH = mhsa_mem_pkg::WIDTH,
  parameter int CNT_W = mhsa_mem_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             mem_write_en,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_data_in,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic [1:0]       dbg_state
);

  import mhsa_mem_pkg::*;

  fetch_state_t     r_state;
  logic [31:0]      r_base;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_issued;
  logic             r_inflight;
  logic             r_inflight_last;
  logic             r_done;

  logic             w_ld_xfer;
  logic             w_pop;
  logic             w_issue;
  logic             w_issue_last;
  logic [2:0]       w_occ_after;
  logic             w_drain_empty;
  logic [31:0]      w_rd_addr;
  logic [1:0]       w_fifo_cnt;
  logic [WIDTH:0]   w_head;

  assign ld_ready  = (r_state == IDLE);
  assign w_ld_xfer = ld_valid & ld_ready;

  assign out_valid = (w_fifo_cnt != 2'd0);
  assign out_data  = out_valid ? w_head[WIDTH-1:0] : '0;
  assign out_last  = out_valid & w_head[WIDTH];
  assign w_pop     = out_valid & out_ready;

  // Words that will occupy the buffer once this cycle's pop and the in-flight
  // read are accounted for; a new read is only safe if that leaves a free slot.
  assign w_occ_after   = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue       = (r_state == READ) && (r_issued < r_num) && (w_occ_after < 3'd2);
  assign w_issue_last  = ((r_issued + CNT_W'(1)) == r_num);
  assign w_rd_addr     = r_base + 32'(r_issued);
  assign w_drain_empty = !r_inflight && (w_occ_after == 3'd0);

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

  // Memory port mux: loader write in IDLE, otherwise a read when one issues.
  always_comb begin
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    if (w_ld_xfer) begin
      mem_write_en = 1'b1;
      mem_addr     = ld_addr;
      mem_data_in  = ld_data;
    end else if (w_issue) begin
      mem_addr = w_rd_addr;
    end
  end

  // Burst sequencer: latch the request, issue reads, then wait for the buffer to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_base          <= '0;
      r_num           <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_issue_last;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base   <= base_addr;
            r_num    <= num_words;
            r_issued <= '0;
            r_state  <= READ;
          end
        end
        READ: begin
          if (w_issue) r_issued <= r_issued + CNT_W'(1);
          if ((r_issued >= r_num) || (w_issue && w_issue_last)) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_drain_empty) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  wk_skid_fifo #(.DW(WIDTH + 1)) u_skid (
    .clk       (clk),
    .clr       (rst),
    .push      (r_inflight),
    .push_data ({r_inflight_last, mem_data_out}),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_fifo_cnt)
  );

endmodule

// File: tb/tb_wk_fetch_ctrl.sv
// Bench for wk_fetch_ctrl: behavioural memory, shadow copy of memory contents,
// expected-word queue, vector table for loader writes and burst sequences.
module tb_wk_fetch_ctrl;

  localparam int WIDTH = 64;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4096;
  localparam logic [63:0] INJ_DATA = 64'hC0FF_EE00_1234_5678;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] num_words;
  logic             busy, done;
  logic             ld_valid, ld_ready;
  logic [31:0]      ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             mem_write_en;
  logic [31:0]      mem_addr;
  logic [WIDTH-1:0] mem_data_in;
  logic [WIDTH-1:0] mem_data_out;
  logic [1:0]       dbg_state;

  wk_fetch_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .dbg_state(dbg_state)
  );

  // Single-port memory with a one-cycle registered read.
  logic [WIDTH-1:0] mem_model [DEPTH];
  always @(posedge clk) begin
    if (mem_write_en) mem_model[mem_addr[11:0]] <= mem_data_in;
    mem_data_out <= mem_model[mem_addr[11:0]];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_q[$];

  int errors = 0;
  int checks = 0;
  int ld_err = 0;
  int st_done, st_first, st_busy, st_max_out, st_iss, st_seq_err, st_intr_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy_of(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_word(input logic [31:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    start = 1'b0; ld_valid = 1'b1; ld_addr = a; ld_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    if (!mem_write_en || mem_addr != a || mem_data_in != d) ld_err++;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    start = 1'b0; ld_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
  endtask

  // Runs one burst; cycle 0 is the cycle start is high. Optional same-cycle
  // loader write to address 0 (pre_v) and mid-burst loader/start intrusion (inj>0).
  task automatic run_burst(input logic [31:0] b, input int n, input int mode, input int inj,
                           input logic pre_v, input logic [63:0] pre_d);
    int cyc;
    int acc;
    logic [63:0] e;
    if (pre_v) ref_mem[0] = pre_d;
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[b + 32'(i)]);
    st_done = -1; st_first = -1; st_busy = 0; st_max_out = 0;
    st_iss = 0; st_seq_err = 0; st_intr_err = 0; acc = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = CNT_W'(n); out_ready = rdy_of(mode, 0);
    ld_valid = pre_v; ld_addr = 32'd0; ld_data = pre_d;
    @(negedge clk);
    if (pre_v) check("same_cycle_write_en", mem_write_en, 1);
    cyc = 0;
    while (st_done < 0 && cyc < n * 8 + 40) begin
      @(posedge clk); #1;
      cyc++;
      start     = (inj > 0) && (cyc == inj || cyc == inj + 1);
      base_addr = start ? b + 32'd1000 : b;
      num_words = start ? CNT_W'(3) : CNT_W'(n);
      ld_valid  = (inj > 0) && (cyc >= inj);
      ld_addr   = 32'd300;
      ld_data   = INJ_DATA;
      out_ready = rdy_of(mode, cyc);
      @(negedge clk);
      if (busy) st_busy++;
      if (out_valid && st_first < 0) st_first = cyc;
      if (b != 0 && busy && !mem_write_en && mem_addr != 0) begin
        if (mem_addr != b + 32'(st_iss)) st_seq_err++;
        st_iss++;
      end
      if (out_valid && out_ready) begin
        acc++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_word: got %h expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          check("word_data", out_data, e);
          check("word_last", out_last, exp_q.size() == 0);
        end
      end
      if (st_iss - acc > st_max_out) st_max_out = st_iss - acc;
      if (ld_valid && busy && (ld_ready || mem_write_en)) st_intr_err++;
      if (done) begin
        st_done = cyc;
        check("busy_low_with_done", busy, 0);
      end
    end
    if (st_done < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", n * 8 + 40);
    end
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [63:0] d;
    logic        e_we;
    logic [31:0] e_addr;
    logic [63:0] e_din;
  } ld_vec_t;

  ld_vec_t vt[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vt[0] = '{1'b1, 32'd10,   64'h1111,                1'b1, 32'd10,   64'h1111};
    vt[1] = '{1'b0, 32'd20,   64'h2222,                1'b0, 32'd0,    64'h0};
    vt[2] = '{1'b1, 32'd4095, 64'hFFFF_0000_FFFF_0000, 1'b1, 32'd4095, 64'hFFFF_0000_FFFF_0000};
    vt[3] = '{1'b0, 32'd4095, 64'h5,                   1'b0, 32'd0,    64'h0};
    vt[4] = '{1'b1, 32'd0,    64'h0123_4567_89AB_CDEF, 1'b1, 32'd0,    64'h0123_4567_89AB_CDEF};
    vt[5] = '{1'b1, 32'd7,    64'h77,                  1'b1, 32'd7,    64'h77};

    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_mem_we", mem_write_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Loader behaviour in IDLE from the vector table.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      ld_valid = vt[i].v; ld_addr = vt[i].a; ld_data = vt[i].d;
      if (vt[i].v) ref_mem[vt[i].a] = vt[i].d;
      @(negedge clk);
      check("vec_ld_ready", ld_ready, 1);
      check("vec_mem_we", mem_write_en, vt[i].e_we);
      check("vec_mem_addr", mem_addr, vt[i].e_addr);
      check("vec_mem_din", mem_data_in, vt[i].e_din);
    end

    // Full matrix load then full-length burst.
    for (int a = 0; a < 2048; a++)
      load_word(32'(a), {32'd0, 32'(a)} ^ 64'hA5A5_A5A5_A5A5_A5A5);
    check("load_writes", ld_err, 0);
    run_burst(32'd0, 2048, 0, 0, 1'b0, 64'd0);
    check("full_first_valid_cyc", st_first, 3);
    check("full_done_cyc", st_done, 2051);
    check("full_busy_cycles", st_busy, 2050);
    idle_cycle();
    check("full_done_single_pulse", done, 0);

    // Backpressure pattern 1,0,0,1.
    run_burst(32'd100, 8, 1, 0, 1'b0, 64'd0);
    check("bp_reads_issued", st_iss, 8);
    check("bp_read_order", st_seq_err, 0);
    check("bp_max_outstanding_le2", st_max_out <= 2, 1);
    idle_cycle();

    // start with a same-cycle loader write to the word being read.
    run_burst(32'd0, 1, 0, 0, 1'b1, 64'hDEAD);
    check("rw_done_cyc", st_done, 4);
    idle_cycle();

    // Zero-length burst.
    run_burst(32'd50, 0, 0, 0, 1'b0, 64'd0);
    check("zero_no_valid", st_first, -1);
    check("zero_no_reads", st_iss, 0);
    check("zero_done_cyc", st_done, 3);
    check("zero_busy_cycles", st_busy, 2);
    idle_cycle();
    check("zero_done_single_pulse", done, 0);

    // Loader write and second start during a burst.
    run_burst(32'd200, 16, 2, 4, 1'b0, 64'd0);
    check("inj_blocked", st_intr_err, 0);
    check("inj_reads_issued", st_iss, 16);
    check("inj_write_after_done", mem_write_en, 1);
    check("inj_write_addr", mem_addr, 300);
    ref_mem[300] = INJ_DATA;
    idle_cycle();
    check("inj_no_restart", busy, 0);
    run_burst(32'd300, 1, 0, 0, 1'b0, 64'd0);
    idle_cycle();

    // Reset in the middle of a burst.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'd500; num_words = CNT_W'(16); out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("mid_busy_before_rst", busy, 1);
    check("mid_valid_before_rst", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_ld_ready", ld_ready, 1);
    check("mid_rst_mem_we", mem_write_en, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_din", mem_data_in, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_burst(32'd600, 16, 2, 0, 1'b0, 64'd0);
    check("post_rst_reads", st_iss, 16);
    idle_cycle();

    // Randomized loader writes and bursts.
    for (int r = 0; r < 6; r++) begin
      int nb;
      logic [31:0] bb;
      for (int k = 0; k < 3; k++)
        load_word(32'($urandom_range(0, 2047)), {$urandom, $urandom});
      bb = 32'($urandom_range(1, 2000));
      nb = $urandom_range(1, 40);
      run_burst(bb, nb, 2, 0, 1'b0, 64'd0);
      check("rnd_reads_issued", st_iss, nb);
      check("rnd_read_order", st_seq_err, 0);
      check("rnd_max_outstanding_le2", st_max_out <= 2, 1);
      idle_cycle();
      check("rnd_done_single_pulse", done, 0);
    end
    check("rnd_load_writes", ld_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
